// File: rtl/pong_pkg.sv
// Shared encodings for the Pong datapath: match FSM states and winner codes.
package pong_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_SERVE = 3'd1;
    localparam logic [STATE_W-1:0] ST_PLAY  = 3'd2;
    localparam logic [STATE_W-1:0] ST_POINT = 3'd3;
    localparam logic [STATE_W-1:0] ST_OVER  = 3'd4;

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_LEFT  = 2'b01;
    localparam logic [1:0] WIN_RIGHT = 2'b10;

endpackage

// File: rtl/key_edge_detect.sv
// Brings a raw active-low push button into the clk domain and emits a
// one-cycle pulse on each press (falling edge of key_n).
module key_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic pulse
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic r_pulse;

    // Two-flop synchroniser, previous-level flop and registered press pulse.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous; flops reset to 1 so a released key does not fire a pulse.
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
            r_pulse <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep each stage one cycle behind the previous.
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_pulse <= r_prev & ~r_sync2;
        end
    end

    assign pulse = r_pulse;

endmodule

// File: rtl/match_sequencer.sv
// Match-level controller for Pong: sequences idle/serve/rally/point/over,
// owns both score counters and drives the game logic's run and recentre.
module match_sequencer
    import pong_pkg::*;
#(
    parameter int SCORE_W     = 4,
    parameter int WIN_SCORE   = 9,
    parameter int SERVE_DELAY = 25_000_000,
    parameter int CNT_W       = 25
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_key_n,
    input  logic               pause,
    input  logic               random_bit,
    input  logic               miss_left,
    input  logic               miss_right,
    output logic               logic_run,
    output logic               ball_reset,
    output logic               serve_dir,
    output logic [SCORE_W-1:0] score_left,
    output logic [SCORE_W-1:0] score_right,
    output logic [1:0]         winner,
    output logic [2:0]         state
);

    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(SERVE_DELAY - 1);
    localparam logic [SCORE_W-1:0] SCORE_WIN = SCORE_W'(WIN_SCORE);

    logic                w_start;
    logic [STATE_W-1:0]  r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [SCORE_W-1:0]  r_score_l;
    logic [SCORE_W-1:0]  r_score_r;
    logic [1:0]          r_winner;
    logic                r_run;
    logic                r_ball_reset;
    logic                r_serve_dir;
    // Remembers who conceded the last point so the next serve goes toward them.
    logic                r_concede_right;

    key_edge_detect u_start_key (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (start_key_n),
        .pulse (w_start)
    );

    // Match FSM with serve counter, score registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_cnt           <= '0;
            r_score_l       <= '0;
            r_score_r       <= '0;
            r_winner        <= WIN_NONE;
            r_run           <= 1'b0;
            r_ball_reset    <= 1'b0;
            r_serve_dir     <= 1'b0;
            r_concede_right <= 1'b0;
        end else begin
            r_ball_reset <= 1'b0;
            r_run        <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_score_l <= '0;
                    r_score_r <= '0;
                    r_winner  <= WIN_NONE;
                    r_cnt     <= '0;
                    if (w_start) begin
                        r_state      <= ST_SERVE;
                        r_ball_reset <= 1'b1;
                        r_serve_dir  <= random_bit;
                    end
                end
                ST_SERVE: begin
                    if (!pause) begin
                        if (r_cnt == CNT_LAST) begin
                            r_state <= ST_PLAY;
                            r_cnt   <= '0;
                            r_run   <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_PLAY: begin
                    r_run <= ~pause;
                    if (!pause) begin
                        if (miss_left && miss_right) begin
                            r_state      <= ST_SERVE;
                            r_ball_reset <= 1'b1;
                            r_serve_dir  <= random_bit;
                            r_run        <= 1'b0;
                        end else if (miss_left) begin
                            r_score_r       <= r_score_r + SCORE_W'(1);
                            r_concede_right <= 1'b0;
                            r_state         <= ST_POINT;
                            r_run           <= 1'b0;
                        end else if (miss_right) begin
                            r_score_l       <= r_score_l + SCORE_W'(1);
                            r_concede_right <= 1'b1;
                            r_state         <= ST_POINT;
                            r_run           <= 1'b0;
                        end
                    end
                end
                ST_POINT: begin
                    if (r_score_l == SCORE_WIN) begin
                        r_state  <= ST_OVER;
                        r_winner <= WIN_LEFT;
                    end else if (r_score_r == SCORE_WIN) begin
                        r_state  <= ST_OVER;
                        r_winner <= WIN_RIGHT;
                    end else begin
                        r_state      <= ST_SERVE;
                        r_ball_reset <= 1'b1;
                        r_serve_dir  <= r_concede_right;
                        r_cnt        <= '0;
                    end
                end
                ST_OVER: begin
                    if (w_start) begin
                        r_score_l    <= '0;
                        r_score_r    <= '0;
                        r_winner     <= WIN_NONE;
                        r_cnt        <= '0;
                        r_state      <= ST_SERVE;
                        r_ball_reset <= 1'b1;
                        r_serve_dir  <= random_bit;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_cnt     <= '0;
                    r_score_l <= '0;
                    r_score_r <= '0;
                    r_winner  <= WIN_NONE;
                end
            endcase
        end
    end

    assign logic_run   = r_run;
    assign ball_reset  = r_ball_reset;
    assign serve_dir   = r_serve_dir;
    assign score_left  = r_score_l;
    assign score_right = r_score_r;
    assign winner      = r_winner;
    assign state       = r_state;

endmodule

// File: tb/tb_match_sequencer.sv
// Self-checking bench for match_sequencer: every recentre pulse is matched
// against a queue of expected serves pushed when the stimulus is driven.
`timescale 1ns/1ps
module tb_match_sequencer;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SERVE = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_POINT = 3'd3;
    localparam logic [2:0] S_OVER  = 3'd4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_key_n = 1'b1;
    logic       pause = 1'b0;
    logic       random_bit = 1'b0;
    logic       miss_left = 1'b0;
    logic       miss_right = 1'b0;
    logic       logic_run;
    logic       ball_reset;
    logic       serve_dir;
    logic [3:0] score_left;
    logic [3:0] score_right;
    logic [1:0] winner;
    logic [2:0] state;

    typedef struct {
        logic       dir;
        logic [3:0] sl;
        logic [3:0] sr;
    } serve_t;

    serve_t sb_q[$];
    int     n_tests = 0;
    int     n_fail  = 0;
    logic   prev_br = 1'b0;

    match_sequencer #(
        .SCORE_W     (4),
        .WIN_SCORE   (3),
        .SERVE_DELAY (8),
        .CNT_W       (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_key_n (start_key_n),
        .pause       (pause),
        .random_bit  (random_bit),
        .miss_left   (miss_left),
        .miss_right  (miss_right),
        .logic_run   (logic_run),
        .ball_reset  (ball_reset),
        .serve_dir   (serve_dir),
        .score_left  (score_left),
        .score_right (score_right),
        .winner      (winner),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic push_serve(input logic dir, input logic [3:0] sl, input logic [3:0] sr);
        serve_t e;
        e.dir = dir;
        e.sl  = sl;
        e.sr  = sr;
        sb_q.push_back(e);
    endtask

    // Scoreboard monitor: pop an expected serve at every recentre pulse.
    always @(negedge clk) begin
        if (ball_reset) begin
            check("br_consecutive", 32'(prev_br), 32'd0);
            if (sb_q.size() > 0) begin
                serve_t e;
                e = sb_q.pop_front();
                check("serve_dir", 32'(serve_dir), 32'(e.dir));
                check("serve_score_l", 32'(score_left), 32'(e.sl));
                check("serve_score_r", 32'(score_right), 32'(e.sr));
            end else begin
                check("br_unexpected", 32'd0, 32'd1);
            end
        end
        prev_br = ball_reset;
    end

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int n = 0;
        while (state !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(state), 32'(s));
    endtask

    // Counts cycles from SERVE entry to the first PLAY cycle, pausing on a schedule.
    task automatic serve_len(input int p_start, input int p_len, input int expected, input string tag);
        int n = 0;
        while (state !== S_PLAY && n < 100) begin
            @(negedge clk);
            n++;
            if (n == p_start) pause = 1'b1;
            if (n == p_start + p_len) pause = 1'b0;
        end
        pause = 1'b0;
        check(tag, 32'(n), 32'(expected));
        check({tag, "_run"}, 32'(logic_run), 32'd1);
    endtask

    task automatic press_start(input string tag);
        start_key_n = 1'b0;
        wait_state(S_SERVE, 12, tag);
        start_key_n = 1'b1;
    endtask

    task automatic pulse_miss(input logic l, input logic r);
        miss_left  = l;
        miss_right = r;
        @(negedge clk);
        miss_left  = 1'b0;
        miss_right = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_state", 32'(state), 32'(S_IDLE));
        check("rst_scores", {24'd0, score_left, score_right}, 32'd0);
        check("rst_outs", {28'd0, winner, logic_run, ball_reset}, 32'd0);
        check("rst_dir", 32'(serve_dir), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_hold", 32'(state), 32'(S_IDLE));

        // Serve start with random_bit = 1
        random_bit = 1'b1;
        push_serve(1'b1, 4'd0, 4'd0);
        press_start("start_serve");
        check("serve_br", 32'(ball_reset), 32'd1);
        serve_len(-1, 0, 8, "serve1_len");

        // Pause during PLAY: run drops, miss ignored
        pause = 1'b1;
        @(negedge clk);
        check("pause_run", 32'(logic_run), 32'd0);
        pulse_miss(1'b1, 1'b0);
        check("pause_miss_state", 32'(state), 32'(S_PLAY));
        check("pause_miss_score", 32'(score_right), 32'd0);
        pause = 1'b0;
        @(negedge clk);
        check("unpause_run", 32'(logic_run), 32'd1);

        // Scoring by miss_right
        push_serve(1'b1, 4'd1, 4'd0);
        pulse_miss(1'b0, 1'b1);
        check("point_state", 32'(state), 32'(S_POINT));
        check("point_score_l", 32'(score_left), 32'd1);
        check("point_run", 32'(logic_run), 32'd0);
        @(negedge clk);
        check("point_to_serve", 32'(state), 32'(S_SERVE));
        check("point_br", 32'(ball_reset), 32'd1);

        // Pause for 20 cycles during SERVE
        serve_len(2, 20, 28, "serve_paused_len");

        // Simultaneous misses
        random_bit = 1'b0;
        push_serve(1'b0, 4'd1, 4'd0);
        pulse_miss(1'b1, 1'b1);
        check("both_state", 32'(state), 32'(S_SERVE));
        check("both_br", 32'(ball_reset), 32'd1);
        check("both_scores", {24'd0, score_left, score_right}, {24'd0, 4'd1, 4'd0});
        serve_len(-1, 0, 8, "serve_both_len");

        // Match end: three miss_left pulses
        for (int i = 1; i <= 3; i++) begin
            if (i < 3) push_serve(1'b0, 4'd1, 4'(i));
            pulse_miss(1'b1, 1'b0);
            check("end_point", 32'(state), 32'(S_POINT));
            check("end_score_r", 32'(score_right), 32'(i));
            @(negedge clk);
            if (i < 3) begin
                check("end_serve", 32'(state), 32'(S_SERVE));
                serve_len(-1, 0, 8, "end_serve_len");
            end
        end
        check("over_state", 32'(state), 32'(S_OVER));
        check("over_winner", 32'(winner), 32'd2);
        pulse_miss(1'b1, 1'b0);
        pulse_miss(1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check("over_hold", {20'd0, state, winner, score_left, score_right},
              {20'd0, S_OVER, 2'b10, 4'd1, 4'd3});
        random_bit = 1'b1;
        push_serve(1'b1, 4'd0, 4'd0);
        press_start("restart");
        check("restart_clear", {22'd0, winner, score_left, score_right}, 32'd0);
        serve_len(-1, 0, 8, "restart_len");

        // Reset mid-rally with score_left = 2
        for (int i = 1; i <= 2; i++) begin
            push_serve(1'b1, 4'(i), 4'd0);
            pulse_miss(1'b0, 1'b1);
            @(negedge clk);
            serve_len(-1, 0, 8, "prerst_len");
        end
        check("prerst_score_l", 32'(score_left), 32'd2);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_state", 32'(state), 32'(S_IDLE));
        check("midrst_outs", {22'd0, winner, score_left, score_right}, 32'd0);
        check("midrst_ctl", {29'd0, logic_run, ball_reset, serve_dir}, 32'd0);

        // Illegal state recovers to IDLE
        force dut.r_state = 3'd6;
        #1;
        release dut.r_state;
        @(negedge clk);
        check("illegal_recover", 32'(state), 32'(S_IDLE));

        repeat (2) @(negedge clk);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
